lm_sm_sequencer: RTL and testbench

Multi-cycle sequencer that expands one decoded load-multiple (LM) or store-multiple (SM) instruction into a stream of single-register memory micro-ops. It sits between the instruction decoder and the ID_RF pipeline register. While the expansion runs, it freezes PC and IF_ID and injects one micro-op per cycle into ID_RF. Micro-ops then travel the normal RF/EX/M/WB path, using base register plus offset as the address.

---
 rtl/lm_sm_pkg.sv | 22 ++
 rtl/lsb_priority_encoder_8.sv | 24 ++
 rtl/lm_sm_sequencer.sv | 121 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lm_sm_pkg.sv
// Shared types and constants for the LM/SM micro-op sequencer.
package lm_sm_pkg;

  localparam int unsigned MASK_W = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned OFF_W  = 3;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  typedef struct packed {
    logic              store;
    logic [REG_AW-1:0] data_reg;
    logic [REG_AW-1:0] base;
    logic [OFF_W-1:0]  offset;
    logic              first;
    logic              last;
  } uop_t;

endpackage

// File: rtl/lsb_priority_encoder_8.sv
// Finds the lowest set bit of an 8-bit register mask and returns the mask with that bit cleared.
module lsb_priority_encoder_8
  import lm_sm_pkg::*;
(
  input  logic [MASK_W-1:0] mask_i,
  output logic [REG_AW-1:0] idx_o,
  output logic              found_o,
  output logic [MASK_W-1:0] rem_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (mask_i[i] && !found_o) begin
        idx_o   = i[REG_AW-1:0];
        found_o = 1'b1;
      end
    end
  end

  assign rem_o = mask_i & (mask_i - MASK_W'(1));

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands a decoded LM/SM instruction into one single-register memory micro-op per cycle.
module lm_sm_sequencer #(
  parameter int unsigned MASK_W = lm_sm_pkg::MASK_W,
  parameter int unsigned REG_AW = lm_sm_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [REG_AW-1:0] base_reg,
  input  logic [MASK_W-1:0] reg_mask,
  input  logic              hold,
  input  logic              flush,
  output logic              busy,
  output logic              uop_valid,
  output logic              uop_store,
  output logic [REG_AW-1:0] uop_reg,
  output logic [REG_AW-1:0] uop_base,
  output logic [2:0]        uop_offset,
  output logic              uop_first,
  output logic              uop_last,
  output logic              done
);

  import lm_sm_pkg::*;

  state_e            state_q, state_d;
  uop_t              uop_q, uop_d;
  logic [MASK_W-1:0] rem_q, rem_d;
  logic              done_q, done_d;
  logic              take_start;

  logic [MASK_W-1:0] enc_src, enc_rem;
  logic [REG_AW-1:0] enc_idx;
  logic              enc_found;

  // One encoder serves both the continuing sequence and a newly accepted mask.
  assign enc_src = (state_q == ISSUE && !uop_q.last) ? rem_q : reg_mask;

  lsb_priority_encoder_8 u_enc (
    .mask_i  (enc_src),
    .idx_o   (enc_idx),
    .found_o (enc_found),
    .rem_o   (enc_rem)
  );

  always_comb begin
    state_d    = state_q;
    uop_d      = uop_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    take_start = 1'b0;
    if (flush) begin
      state_d = IDLE;
      uop_d   = '0;
      rem_d   = '0;
    end else if (hold) begin
      done_d = done_q;
    end else begin
      case (state_q)
        IDLE: take_start = start;
        ISSUE: begin
          if (!uop_q.last) begin
            uop_d.data_reg = enc_idx;
            uop_d.offset   = uop_q.offset + 1'b1;
            uop_d.first    = 1'b0;
            uop_d.last     = (enc_rem == '0);
            rem_d          = enc_rem;
          end else begin
            // Accepting the last micro-op also accepts a back-to-back start.
            state_d    = IDLE;
            uop_d      = '0;
            rem_d      = '0;
            done_d     = 1'b1;
            take_start = start;
          end
        end
        default: state_d = IDLE;
      endcase
      if (take_start) begin
        if (enc_found) begin
          state_d        = ISSUE;
          uop_d.store    = is_store;
          uop_d.data_reg = enc_idx;
          uop_d.base     = base_reg;
          uop_d.offset   = '0;
          uop_d.first    = 1'b1;
          uop_d.last     = (enc_rem == '0);
          rem_d          = enc_rem;
        end else begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      uop_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == ISSUE);
  assign uop_valid  = (state_q == ISSUE);
  assign uop_store  = uop_q.store;
  assign uop_reg    = uop_q.data_reg;
  assign uop_base   = uop_q.base;
  assign uop_offset = uop_q.offset;
  assign uop_first  = uop_q.first;
  assign uop_last   = uop_q.last;
  assign done       = done_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench: directed vector table, async-reset sequence, and randomized run against a queue model.
module tb_lm_sm_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [2:0] base_reg = '0;
  logic [7:0] reg_mask = '0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;

  logic       busy, uop_valid, uop_store, uop_first, uop_last, done;
  logic [2:0] uop_reg, uop_base, uop_offset;

  lm_sm_sequencer #(.MASK_W(8), .REG_AW(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .base_reg   (base_reg),
    .reg_mask   (reg_mask),
    .hold       (hold),
    .flush      (flush),
    .busy       (busy),
    .uop_valid  (uop_valid),
    .uop_store  (uop_store),
    .uop_reg    (uop_reg),
    .uop_base   (uop_base),
    .uop_offset (uop_offset),
    .uop_first  (uop_first),
    .uop_last   (uop_last),
    .done       (done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        start;
    logic        st;
    logic [2:0]  base;
    logic [7:0]  mask;
    logic        hold;
    logic        flush;
    logic [14:0] exp;
  } vec_t;

  // {busy, uop_valid, uop_store, uop_reg, uop_base, uop_offset, uop_first, uop_last, done}
  function automatic logic [14:0] outs();
    return {busy, uop_valid, uop_store, uop_reg, uop_base, uop_offset, uop_first, uop_last, done};
  endfunction

  function automatic logic [14:0] U(input logic st, input logic [2:0] b, input logic [2:0] r,
                                    input logic [2:0] o, input logic f, input logic l, input logic d);
    return {1'b1, 1'b1, st, r, b, o, f, l, d};
  endfunction

  function automatic logic [14:0] Z(input logic d);
    return {14'h0, d};
  endfunction

  function automatic vec_t V(input logic s, input logic st, input logic [2:0] b, input logic [7:0] m,
                             input logic h, input logic f, input logic [14:0] e);
    vec_t v;
    v.start = s; v.st = st; v.base = b; v.mask = m; v.hold = h; v.flush = f; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = outs();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic [2:0] b, input logic [7:0] m,
                       input logic h, input logic f);
    start = s; is_store = st; base_reg = b; reg_mask = m; hold = h; flush = f;
    @(posedge clock);
    #1;
  endtask

  // Reference model: pending registers kept as a queue of indices.
  bit   m_act = 0, m_st = 0, m_done = 0;
  int   m_base = 0, m_reg = 0, m_off = 0;
  int   m_q[$];

  task automatic model_step(input logic s, input logic st, input logic [2:0] b, input logic [7:0] m,
                            input logic h, input logic f);
    bit can_start;
    int regs[$];
    if (f) begin
      m_act = 0; m_done = 0; m_q.delete();
    end else if (!h) begin
      can_start = !m_act;
      m_done = 0;
      if (m_act) begin
        if (m_q.size() > 0) begin
          m_reg = m_q.pop_front();
          m_off++;
        end else begin
          m_act = 0; m_done = 1; can_start = 1;
        end
      end
      if (can_start && s) begin
        for (int i = 0; i < 8; i++) if (m[i]) regs.push_back(i);
        if (regs.size() == 0) m_done = 1;
        else begin
          m_act = 1; m_st = st; m_base = int'(b); m_off = 0;
          m_reg = regs.pop_front();
          m_q = regs;
        end
      end
    end
  endtask

  function automatic logic [14:0] model_exp();
    if (m_act)
      return U(m_st, 3'(m_base), 3'(m_reg), 3'(m_off), m_off == 0, m_q.size() == 0, m_done);
    return Z(m_done);
  endfunction

  vec_t tbl[$];

  initial begin
    // LM base R6, mask 0010_0101
    tbl.push_back(V(1, 0, 6, 8'h25, 0, 0, U(0, 6, 0, 0, 1, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(0, 6, 2, 1, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(0, 6, 5, 2, 0, 1, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(1)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(0)));
    // SM mask FF, hold two cycles on R2
    tbl.push_back(V(1, 1, 1, 8'hFF, 0, 0, U(1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 1, 1, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 2, 2, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, U(1, 1, 2, 2, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, U(1, 1, 2, 2, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 3, 3, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 4, 4, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 5, 5, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 6, 6, 0, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 1, 7, 7, 0, 1, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(1)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(0)));
    // Empty mask: done only; hold in idle freezes done
    tbl.push_back(V(1, 0, 4, 8'h00, 0, 0, Z(1)));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, Z(1)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(0)));
    // SM mask 1000_0001, flush during R7 (start alongside flush is ignored)
    tbl.push_back(V(1, 1, 3, 8'h81, 0, 0, U(1, 3, 0, 0, 1, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(1, 3, 7, 1, 0, 1, 0)));
    tbl.push_back(V(1, 0, 2, 8'h10, 0, 1, Z(0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(0)));
    // Back-to-back: 03 then 04 on the done edge
    tbl.push_back(V(1, 0, 2, 8'h03, 0, 0, U(0, 2, 0, 0, 1, 0, 0)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, U(0, 2, 1, 1, 0, 1, 0)));
    tbl.push_back(V(1, 1, 4, 8'h04, 0, 0, U(1, 4, 2, 0, 1, 1, 1)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(1)));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, Z(0)));

    #1;
    check("reset_state", Z(0));
    #11 reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      begin
        drive(tbl[i].start, tbl[i].st, tbl[i].base, tbl[i].mask, tbl[i].hold, tbl[i].flush);
        check($sformatf("table[%0d]", i), tbl[i].exp);
      end

    // Asynchronous reset mid-sequence, then a single-register LM
    drive(1, 0, 5, 8'h0F, 0, 0);
    check("rst_seq_uop0", U(0, 5, 0, 0, 1, 0, 0));
    drive(0, 0, 0, 8'h00, 0, 0);
    check("rst_seq_uop1", U(0, 5, 1, 1, 0, 0, 0));
    #3 reset = 1'b0;
    #1 check("async_reset", Z(0));
    #2 reset = 1'b1;
    drive(1, 0, 2, 8'h80, 0, 0);
    check("after_reset_r7", U(0, 2, 7, 0, 1, 1, 0));
    drive(0, 0, 0, 8'h00, 0, 0);
    check("after_reset_done", Z(1));
    drive(0, 0, 0, 8'h00, 0, 0);
    check("after_reset_idle", Z(0));

    // Randomized run against the queue model (DUT and model both idle here)
    for (int c = 0; c < 800; c++) begin
      logic       s, st, h, f;
      logic [2:0] b;
      logic [7:0] m;
      s  = ($urandom_range(0, 9) < 4);
      st = 1'($urandom);
      b  = 3'($urandom);
      m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      h  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 19) == 0);
      drive(s, st, b, m, h, f);
      model_step(s, st, b, m, h, f);
      check($sformatf("random[%0d]", c), model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
